pll_div_bank: RTL and testbench
===============================

Name: pll_div_bank

Overview:
- Parametrised, reconfigurable successor to the fixed-parameter PLL simulation model.
- Derives NUM_OUT divided clock outputs and clock-enable pulses from one input clock, each with its own divide, high time and phase offset, all counted in input cycles.
- Adds a lock sequence, power-down, and a DRP-style port for runtime reconfiguration with automatic relock.
- Used in simulation benches and as a synthesizable clock-enable generator.

Parameters:
- NUM_OUT, 4, number of output channels (1..32).
- DIV_W, 8, width of the per-channel divide, high and phase fields (2..16).
- LOCK_CYCLES, 64, input cycles from start of lock sequence to LOCKED=1 (>=1).
- DIV_INIT, {8'd8,8'd4,8'd2,8'd1}, packed NUM_OUT*DIV_W reset divide values; channel i in bits [i*DIV_W +: DIV_W].
- HIGH_INIT, {8'd4,8'd2,8'd1,8'd1}, packed reset high-time values.
- PHASE_INIT, 0, packed reset phase offsets.

Ports:
- CLKIN1  in  1  sole clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- PWRDWN  in  1  power-down request, sampled synchronously.
- CLKOUT  out  NUM_OUT  divided clock outputs, registered.
- CLKOUT_CE  out  NUM_OUT  one-cycle enable at each channel period start, registered.
- LOCKED  out  1  outputs valid.
- DADDR  in  7  [6:2]=channel, [1:0]=field (0 divide, 1 high, 2 phase, 3 reserved).
- DI  in  16  write data; low DIV_W bits used.
- DEN  in  1  access strobe, one cycle.
- DWE  in  1  write qualifier with DEN.
- DO  out  16  read data, zero-extended.
- DRDY  out  1  access acknowledge.

Behaviour:
- Reset values:
  - CLKOUT=0, CLKOUT_CE=0, LOCKED=0, DO=0, DRDY=0.
  - Config registers loaded from DIV_INIT, HIGH_INIT and PHASE_INIT.
  - FSM enters WAIT_LOCK with the lock counter at 0.
- FSM states:
  - OFF: PWRDWN=1. All outputs except DO/DRDY held 0. Exits to WAIT_LOCK on PWRDWN=0.
  - WAIT_LOCK: lock counter increments each cycle. After LOCK_CYCLES cycles, goes to RUN with LOCKED=1 on the following edge; first LOCKED=1 edge is the LOCK_CYCLES-th edge after RST falls.
  - RUN: channels active.
  - PWRDWN=1 in any state goes to OFF on the next edge and overrides everything else.
- Channel timing: k=0 is the first cycle with LOCKED=1.
  - k<phase: CLKOUT[i]=0, CE[i]=0.
  - Otherwise m=(k-phase) mod div; CLKOUT[i]=(m<high), CLKOUT_CE[i]=(m==0).
  - Outputs are registered, so the implementation precomputes one cycle ahead.
- Divide, high and phase edge cases:
  - div=0 is treated as 1. div=1 gives CLKOUT=1 and CE=1 every cycle after phase.
  - high>=div gives CLKOUT constantly 1 after phase; high=0 gives CLKOUT constantly 0 while CE still pulses.
  - Phase is unbounded within DIV_W; it is an initial delay only, not taken modulo div.
- While LOCKED=0, CLKOUT and CLKOUT_CE are 0.
- DRP access:
  - DRDY=1 exactly one cycle after each DEN=1; back-to-back DEN is allowed, one DRDY per DEN.
  - Reads: DO is valid in the DRDY cycle and holds until the next access. Field 3 or channel>=NUM_OUT reads 0.
  - Writes: a valid write updates the register and forces WAIT_LOCK with the counter cleared. LOCKED drops on the next edge and all channel counters clear.
  - A write during WAIT_LOCK restarts the lock count.
  - Writes to field 3 or channel>=NUM_OUT are ignored with no relock, but DRDY is still returned.
  - DEN during OFF is serviced normally; the write takes effect with no relock needed.
- RST mid-operation immediately clears all outputs and reloads the INIT values. A DRDY that is pending is dropped.

Test Plan:
- Defaults, RST released at edge 0 -> LOCKED rises at edge 64. Ch0 CLKOUT=1 constantly. Ch1 toggles every cycle. Ch2 pattern 1100. Ch3 pattern 11110000. CE pulse periods are 1, 2, 4 and 8 respectively.
- Write ch2 phase=3, then divide=5, high=2 -> each write drops LOCKED and restarts the count. After relock, ch2 stays 0 for 3 cycles, then repeats 11000 with CE at each leading 1.
- Read ch3 divide (DADDR=7'h0C) -> DRDY one cycle later with DO=16'h0008. Read DADDR=7'h7F -> DO=0. Write to field 3 -> DRDY returned, LOCKED stays 1.
- Write ch1 divide=0, then ch1 high=0 -> divide=0 behaves as 1 (constant high). high=0 gives CLKOUT constantly 0 while CE still pulses every cycle.
- PWRDWN=1 for 10 cycles mid-RUN -> next edge has LOCKED=0 and all CLKOUT/CE 0. Release -> LOCKED returns LOCKED_CYCLES edges later and channels restart at k=0.
- RST asserted during WAIT_LOCK with a prior write of ch0 divide=3 -> outputs clear asynchronously and ch0 divide reads back 1 after reset.

Source files
------------

// File: rtl/pll_div_bank.sv
// Reconfigurable clock divider bank: NUM_OUT divided clocks and clock enables from CLKIN1,
// with a lock sequence, power-down and a DRP-style port whose writes force a relock.
module pll_div_bank #(
    parameter int                         NUM_OUT     = 4,
    parameter int                         DIV_W       = 8,
    parameter int                         LOCK_CYCLES = 64,
    parameter logic [NUM_OUT*DIV_W-1:0]   DIV_INIT    = {8'd8, 8'd4, 8'd2, 8'd1},
    parameter logic [NUM_OUT*DIV_W-1:0]   HIGH_INIT   = {8'd4, 8'd2, 8'd1, 8'd1},
    parameter logic [NUM_OUT*DIV_W-1:0]   PHASE_INIT  = '0
) (
    input  logic               CLKIN1,
    input  logic               RST,
    input  logic               PWRDWN,
    output logic [NUM_OUT-1:0] CLKOUT,
    output logic [NUM_OUT-1:0] CLKOUT_CE,
    output logic               LOCKED,
    input  logic [6:0]         DADDR,
    input  logic [15:0]        DI,
    input  logic               DEN,
    input  logic               DWE,
    output logic [15:0]        DO,
    output logic               DRDY
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int MW  = DIV_W + 1;

    typedef enum logic [1:0] {ST_OFF, ST_WAIT_LOCK, ST_RUN} state_e;

    state_e             state_q, state_d;
    logic [LCW-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q   [NUM_OUT];
    logic [DIV_W-1:0]   high_q  [NUM_OUT];
    logic [DIV_W-1:0]   phase_q [NUM_OUT];
    logic [DIV_W-1:0]   k_q [NUM_OUT], k_d [NUM_OUT];
    logic [DIV_W-1:0]   m_q [NUM_OUT], m_d [NUM_OUT];
    logic [MW-1:0]      m_inc [NUM_OUT];
    logic [NUM_OUT-1:0] clk_q, clk_d, ce_q, ce_d;
    logic               locked_q, run_d;
    logic [15:0]        do_q, rd_data;
    logic               drdy_q;

    logic [4:0] dchan;
    logic [1:0] dfield;
    logic       chan_ok, wr_cfg;
    logic       unused_di;

    assign dchan     = DADDR[6:2];
    assign dfield    = DADDR[1:0];
    assign chan_ok   = (32'(dchan) < NUM_OUT);
    assign wr_cfg    = DEN && DWE && chan_ok && (dfield != 2'd3);
    assign unused_di = ^DI;

    // NOTE: the config bank is small and must come back to the INIT values on RST,
    // so it is reset like ordinary flops rather than treated as an unreset memory.
    always_ff @(posedge CLKIN1 or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
                high_q[i]  <= HIGH_INIT[i*DIV_W +: DIV_W];
                phase_q[i] <= PHASE_INIT[i*DIV_W +: DIV_W];
            end
        end else if (wr_cfg) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (dchan == 5'(i)) begin
                    case (dfield)
                        2'd0:    div_q[i]   <= DI[DIV_W-1:0];
                        2'd1:    high_q[i]  <= DI[DIV_W-1:0];
                        2'd2:    phase_q[i] <= DI[DIV_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (dchan == 5'(i)) begin
                case (dfield)
                    2'd0:    rd_data = 16'(div_q[i]);
                    2'd1:    rd_data = 16'(high_q[i]);
                    2'd2:    rd_data = 16'(phase_q[i]);
                    default: rd_data = '0;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLKIN1 or posedge RST) begin
        if (RST) begin
            drdy_q <= 1'b0;
            do_q   <= '0;
        end else begin
            drdy_q <= DEN;
            if (DEN && !DWE) do_q <= rd_data;
        end
    end

    always_ff @(posedge CLKIN1 or posedge RST) begin
        if (RST) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Power-down wins over everything; a valid config write restarts the lock count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (PWRDWN) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    if (wr_cfg) begin
                        cnt_d = '0;
                    end else if (cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LCW'(1);
                    end
                end
                ST_RUN: begin
                    if (wr_cfg) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // k_q counts the phase delay, m_q the position in the period, both for the next output cycle.
    always_comb begin
        run_d = (state_d == ST_RUN);
        clk_d = '0;
        ce_d  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            k_d[i]   = '0;
            m_d[i]   = '0;
            m_inc[i] = {1'b0, m_q[i]} + MW'(1);
            if (run_d) begin
                if (k_q[i] < phase_q[i]) begin
                    k_d[i] = k_q[i] + DIV_W'(1);
                end else begin
                    k_d[i]   = k_q[i];
                    clk_d[i] = (m_q[i] < high_q[i]);
                    ce_d[i]  = (m_q[i] == '0);
                    m_d[i]   = (m_inc[i] >= {1'b0, div_q[i]}) ? '0 : m_inc[i][DIV_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge CLKIN1 or posedge RST) begin
        if (RST) begin
            locked_q <= 1'b0;
            clk_q    <= '0;
            ce_q     <= '0;
            for (int i = 0; i < NUM_OUT; i++) begin
                k_q[i] <= '0;
                m_q[i] <= '0;
            end
        end else begin
            locked_q <= run_d;
            clk_q    <= clk_d;
            ce_q     <= ce_d;
            for (int i = 0; i < NUM_OUT; i++) begin
                k_q[i] <= k_d[i];
                m_q[i] <= m_d[i];
            end
        end
    end

    assign CLKOUT    = clk_q;
    assign CLKOUT_CE = ce_q;
    assign LOCKED    = locked_q;
    assign DO        = do_q;
    assign DRDY      = drdy_q;

endmodule

// File: tb/tb_pll_div_bank.sv
// Directed bench for pll_div_bank: lock timing, channel patterns, DRP access, power-down and reset.
module tb_pll_div_bank;

    logic        clk;
    logic        rst;
    logic        pwrdwn;
    logic [3:0]  clkout;
    logic [3:0]  clkout_ce;
    logic        locked;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den;
    logic        dwe;
    logic [15:0] dout;
    logic        drdy;

    int n_checks;
    int n_errors;
    int n_wait;

    // Default-config patterns for k = 0..7; bit i is channel i.
    logic [3:0]  exp_clk [8] = '{4'hF, 4'hD, 4'hB, 4'h9, 4'h7, 4'h5, 4'h3, 4'h1};
    logic [3:0]  exp_ce  [8] = '{4'hF, 4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1};
    // Channel 2 with phase 3, divide 5, high 2, for k = 0..12 (bit k).
    logic [12:0] ch2_clk = 13'h318;
    logic [12:0] ch2_ce  = 13'h108;

    pll_div_bank dut (
        .CLKIN1    (clk),
        .RST       (rst),
        .PWRDWN    (pwrdwn),
        .CLKOUT    (clkout),
        .CLKOUT_CE (clkout_ce),
        .LOCKED    (locked),
        .DADDR     (daddr),
        .DI        (di),
        .DEN       (den),
        .DWE       (dwe),
        .DO        (dout),
        .DRDY      (drdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d);
        daddr = a;
        dwe   = we;
        di    = d;
        den   = 1'b1;
        tick();
        den   = 1'b0;
        dwe   = 1'b0;
    endtask

    task automatic relock(input string tag);
        repeat (63) tick();
        chk({tag, "_edge63"}, 32'(locked), 32'd0);
        tick();
        chk({tag, "_edge64"}, 32'(locked), 32'd1);
    endtask

    task automatic wait_locked(input int max_edges, output int n);
        n = 0;
        while (!locked && n < max_edges) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        pwrdwn = 1'b0;
        daddr  = '0;
        di     = '0;
        den    = 1'b0;
        dwe    = 1'b0;

        // Reset state, then release RST after edge 0.
        @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_clkout", 32'(clkout), 32'd0);
        chk("rst_ce",     32'(clkout_ce), 32'd0);
        chk("rst_drdy",   32'(drdy), 32'd0);
        chk("rst_do",     32'(dout), 32'd0);
        rst = 1'b0;
        relock("init_lock");

        for (int k = 0; k < 16; k++) begin
            chk($sformatf("dflt_clk_k%0d", k), 32'(clkout), 32'(exp_clk[k % 8]));
            chk($sformatf("dflt_ce_k%0d", k),  32'(clkout_ce), 32'(exp_ce[k % 8]));
            tick();
        end

        // Channel 2 reconfiguration: each write drops LOCKED.
        drp(7'h0A, 1'b1, 16'd3);
        chk("wr_phase_drdy",   32'(drdy), 32'd1);
        chk("wr_phase_locked", 32'(locked), 32'd0);
        drp(7'h08, 1'b1, 16'd5);
        chk("wr_div_locked", 32'(locked), 32'd0);
        drp(7'h09, 1'b1, 16'd2);
        chk("wr_high_locked", 32'(locked), 32'd0);
        relock("ch2_lock");
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("ch2_clk_k%0d", k), 32'(clkout[2]), 32'(ch2_clk[k]));
            chk($sformatf("ch2_ce_k%0d", k),  32'(clkout_ce[2]), 32'(ch2_ce[k]));
            chk($sformatf("ch0_clk_k%0d", k), 32'(clkout[0]), 32'd1);
            tick();
        end

        // Back-to-back reads, then ignored writes.
        daddr = 7'h0C;
        dwe   = 1'b0;
        den   = 1'b1;
        tick();
        chk("rd_ch3_drdy", 32'(drdy), 32'd1);
        chk("rd_ch3_do",   32'(dout), 32'h0008);
        daddr = 7'h7F;
        tick();
        den = 1'b0;
        chk("rd_7f_drdy", 32'(drdy), 32'd1);
        chk("rd_7f_do",   32'(dout), 32'h0000);
        tick();
        chk("rd_idle_drdy", 32'(drdy), 32'd0);
        drp(7'h03, 1'b1, 16'd5);
        chk("wr_f3_drdy",   32'(drdy), 32'd1);
        chk("wr_f3_locked", 32'(locked), 32'd1);
        drp(7'h10, 1'b1, 16'd7);
        chk("wr_ch4_drdy", 32'(drdy), 32'd1);
        tick();
        chk("wr_ign_locked", 32'(locked), 32'd1);

        // Channel 1: divide 0 acts as 1, then high 0.
        drp(7'h04, 1'b1, 16'd0);
        relock("ch1_div0");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("div0_clk_k%0d", k), 32'(clkout[1]), 32'd1);
            chk($sformatf("div0_ce_k%0d", k),  32'(clkout_ce[1]), 32'd1);
            tick();
        end
        drp(7'h05, 1'b1, 16'd0);
        relock("ch1_high0");
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("high0_clk_k%0d", k), 32'(clkout[1]), 32'd0);
            chk($sformatf("high0_ce_k%0d", k),  32'(clkout_ce[1]), 32'd1);
            tick();
        end

        // Power-down for 10 cycles.
        pwrdwn = 1'b1;
        tick();
        chk("pd_locked", 32'(locked), 32'd0);
        chk("pd_clkout", 32'(clkout), 32'd0);
        chk("pd_ce",     32'(clkout_ce), 32'd0);
        repeat (9) tick();
        chk("pd_hold_locked", 32'(locked), 32'd0);
        chk("pd_hold_clkout", 32'(clkout), 32'd0);
        pwrdwn = 1'b0;
        wait_locked(200, n_wait);
        chk("pd_relock_lat", 32'(n_wait >= 64 && n_wait <= 65), 32'd1);
        chk("pd_k0_clkout", 32'(clkout), 32'h9);
        chk("pd_k0_ce",     32'(clkout_ce), 32'hB);
        repeat (3) tick();
        chk("pd_k3_clkout", 32'(clkout), 32'hD);
        chk("pd_k3_ce",     32'(clkout_ce), 32'h7);

        // Reset during WAIT_LOCK after a write to channel 0 divide.
        drp(7'h00, 1'b1, 16'd3);
        chk("wr_ch0_locked", 32'(locked), 32'd0);
        repeat (5) tick();
        drp(7'h00, 1'b0, 16'd0);
        chk("rd_ch0_pre_drdy", 32'(drdy), 32'd1);
        chk("rd_ch0_pre_do",   32'(dout), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_drdy",   32'(drdy), 32'd0);
        chk("arst_do",     32'(dout), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_clkout", 32'(clkout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drp(7'h00, 1'b0, 16'd0);
        chk("rd_ch0_post_do", 32'(dout), 32'd1);
        drp(7'h0A, 1'b0, 16'd0);
        chk("rd_ch2_phase_post_do", 32'(dout), 32'd0);
        repeat (61) tick();
        chk("post_rst_edge63", 32'(locked), 32'd0);
        tick();
        chk("post_rst_edge64", 32'(locked), 32'd1);
        chk("post_rst_k0_clkout", 32'(clkout), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
